// File: rtl/c2f_gen2.sv
// rtl/c2f_gen2.sv - core-to-fabric request buffer: oldest-first ring issue, read-tag tracking, broadcast retire
// Entries are matched back from the ring by {CoreID, index}; age is kept in an NxN matrix.
package c2f_gen2_pkg;
  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_RD       = 3'd1,
    OP_WR       = 3'd2,
    OP_WR_BCAST = 3'd3,
    OP_RD_RSP   = 3'd4
  } t_opcode;
endpackage

module c2f_gen2
  import c2f_gen2_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TID_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RQ_W    = 8 + IDX_W
) (
  input  logic              QClk,
  input  logic              RstQnnnL,
  input  logic [7:0]        CoreID,
  input  logic              C2F_ReqValidQ500H,
  input  t_opcode           C2F_ReqOpcodeQ500H,
  input  logic [ADDR_W-1:0] C2F_ReqAddressQ500H,
  input  logic [DATA_W-1:0] C2F_ReqDataQ500H,
  input  logic [TID_W-1:0]  C2F_ReqThreadIDQ500H,
  output logic              C2F_ReqStall,
  output logic              C2F_ReqValidQ501H,
  input  logic              C2F_ReqAckQ501H,
  output logic [RQ_W-1:0]   C2F_ReqRequestorQ501H,
  output t_opcode           C2F_ReqOpcodeQ501H,
  output logic [ADDR_W-1:0] C2F_ReqAddressQ501H,
  output logic [DATA_W-1:0] C2F_ReqDataQ501H,
  input  logic              RingRspInValidQ501H,
  input  logic [RQ_W-1:0]   RingRspInRequestorQ501H,
  input  t_opcode           RingRspInOpcodeQ501H,
  input  logic [DATA_W-1:0] RingRspInDataQ501H,
  output logic              C2F_RingConsumeQ501H,
  output logic              C2F_RspValidQ502H,
  output t_opcode           C2F_RspOpcodeQ502H,
  output logic [DATA_W-1:0] C2F_RspDataQ502H,
  output logic [TID_W-1:0]  C2F_RspThreadIDQ502H
);

  typedef enum logic [2:0] {
    S_FREE, S_PEND_RD, S_PEND_WR, S_PEND_BC, S_RD_WAIT, S_RD_RDY, S_BC_WAIT
  } t_state;

  t_state                          r_state     [ENTRIES];
  t_state                          w_state_nxt [ENTRIES];
  // r_older[j][i] set means entry j was allocated before entry i
  logic [ENTRIES-1:0][ENTRIES-1:0] r_older, w_older_nxt;
  t_opcode                         r_op   [ENTRIES];
  logic [ADDR_W-1:0]               r_addr [ENTRIES];
  logic [DATA_W-1:0]               r_data [ENTRIES];
  logic [TID_W-1:0]                r_tid  [ENTRIES];

  logic [ENTRIES-1:0] w_free, w_pend, w_rdy;
  logic [IDX_W-1:0]   w_alloc_idx, w_iss_idx, w_dlv_idx, w_rsp_idx;
  logic               w_valid_op, w_alloc, w_ack, w_tag_hit, w_rd_hit, w_bc_hit, w_deliver;

  logic               r_rsp_valid;
  t_opcode            r_rsp_op;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [TID_W-1:0]   r_rsp_tid;

  function automatic logic [IDX_W-1:0] f_oldest(input logic [ENTRIES-1:0] set,
                                                input logic [ENTRIES-1:0][ENTRIES-1:0] older);
    logic [IDX_W-1:0] idx;
    logic             beaten;
    idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      beaten = 1'b0;
      for (int j = 0; j < ENTRIES; j++)
        if (set[j] && older[j][i]) beaten = 1'b1;
      if (set[i] && !beaten) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_free      = '0;
    w_pend      = '0;
    w_rdy       = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_free[i] = (r_state[i] == S_FREE);
      w_pend[i] = (r_state[i] == S_PEND_RD) || (r_state[i] == S_PEND_WR) || (r_state[i] == S_PEND_BC);
      w_rdy[i]  = (r_state[i] == S_RD_RDY);
    end
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (w_free[i]) w_alloc_idx = IDX_W'(i);
  end

  assign w_iss_idx  = f_oldest(w_pend, r_older);
  assign w_dlv_idx  = f_oldest(w_rdy, r_older);
  assign w_valid_op = (C2F_ReqOpcodeQ500H == OP_RD) || (C2F_ReqOpcodeQ500H == OP_WR) ||
                      (C2F_ReqOpcodeQ500H == OP_WR_BCAST);
  assign w_alloc    = C2F_ReqValidQ500H && !C2F_ReqStall && w_valid_op;
  assign w_ack      = C2F_ReqAckQ501H && C2F_ReqValidQ501H;
  assign w_rsp_idx  = RingRspInRequestorQ501H[IDX_W-1:0];
  assign w_tag_hit  = RingRspInValidQ501H && (RingRspInRequestorQ501H[RQ_W-1:IDX_W] == CoreID);
  assign w_rd_hit   = w_tag_hit && (r_state[w_rsp_idx] == S_RD_WAIT) && (RingRspInOpcodeQ501H == OP_RD_RSP);
  assign w_bc_hit   = w_tag_hit && (r_state[w_rsp_idx] == S_BC_WAIT) && (RingRspInOpcodeQ501H == OP_WR_BCAST);
  assign w_deliver  = |w_rdy;

  // Alloc, ack, match and delivery always target distinct entries, so updates never collide
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) w_state_nxt[i] = r_state[i];
    w_older_nxt = r_older;
    if (w_alloc) begin
      case (C2F_ReqOpcodeQ500H)
        OP_RD:   w_state_nxt[w_alloc_idx] = S_PEND_RD;
        OP_WR:   w_state_nxt[w_alloc_idx] = S_PEND_WR;
        default: w_state_nxt[w_alloc_idx] = S_PEND_BC;
      endcase
      for (int j = 0; j < ENTRIES; j++) begin
        if (IDX_W'(j) != w_alloc_idx) begin
          w_older_nxt[j][w_alloc_idx] = 1'b1;
          w_older_nxt[w_alloc_idx][j] = 1'b0;
        end
      end
    end
    if (w_ack) begin
      case (r_state[w_iss_idx])
        S_PEND_RD: w_state_nxt[w_iss_idx] = S_RD_WAIT;
        S_PEND_WR: w_state_nxt[w_iss_idx] = S_FREE;
        default:   w_state_nxt[w_iss_idx] = S_BC_WAIT;
      endcase
    end
    if (w_rd_hit)  w_state_nxt[w_rsp_idx] = S_RD_RDY;
    if (w_bc_hit)  w_state_nxt[w_rsp_idx] = S_FREE;
    if (w_deliver) w_state_nxt[w_dlv_idx] = S_FREE;
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_state[i] <= S_FREE;
        r_op[i]    <= OP_NOP;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_tid[i]   <= '0;
      end
      r_older     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= OP_NOP;
      r_rsp_data  <= '0;
      r_rsp_tid   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) r_state[i] <= w_state_nxt[i];
      r_older <= w_older_nxt;
      if (w_alloc) begin
        r_op[w_alloc_idx]   <= C2F_ReqOpcodeQ500H;
        r_addr[w_alloc_idx] <= C2F_ReqAddressQ500H;
        r_data[w_alloc_idx] <= C2F_ReqDataQ500H;
        r_tid[w_alloc_idx]  <= C2F_ReqThreadIDQ500H;
      end
      if (w_rd_hit) r_data[w_rsp_idx] <= RingRspInDataQ501H;
      r_rsp_valid <= w_deliver;
      r_rsp_op    <= w_deliver ? OP_RD_RSP : OP_NOP;
      r_rsp_data  <= w_deliver ? r_data[w_dlv_idx] : '0;
      r_rsp_tid   <= w_deliver ? r_tid[w_dlv_idx] : '0;
    end
  end

  assign C2F_ReqStall          = ~|w_free;
  assign C2F_ReqValidQ501H     = |w_pend;
  assign C2F_ReqRequestorQ501H = C2F_ReqValidQ501H ? {CoreID, w_iss_idx} : '0;
  assign C2F_ReqOpcodeQ501H    = C2F_ReqValidQ501H ? r_op[w_iss_idx] : OP_NOP;
  assign C2F_ReqAddressQ501H   = C2F_ReqValidQ501H ? r_addr[w_iss_idx] : '0;
  assign C2F_ReqDataQ501H      = C2F_ReqValidQ501H ? r_data[w_iss_idx] : '0;
  assign C2F_RingConsumeQ501H  = w_rd_hit || w_bc_hit;
  assign C2F_RspValidQ502H     = r_rsp_valid;
  assign C2F_RspOpcodeQ502H    = r_rsp_op;
  assign C2F_RspDataQ502H      = r_rsp_data;
  assign C2F_RspThreadIDQ502H  = r_rsp_tid;

endmodule

// File: tb/tb_c2f_gen2.sv
// tb/tb_c2f_gen2.sv - scoreboard bench for c2f_gen2
// Stimulus pushes expected ring offers and core responses; a negedge monitor pops and compares.
module tb_c2f_gen2;
  import c2f_gen2_pkg::*;

  localparam logic [7:0] CORE = 8'h5A;

  typedef struct packed {
    logic [9:0]  rq;
    t_opcode     op;
    logic [31:0] addr;
    logic [31:0] data;
  } t_iss;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  tid;
  } t_rsp;

  logic        QClk = 1'b0;
  logic        RstQnnnL = 1'b0;
  logic        req_valid = 1'b0;
  t_opcode     req_op = OP_NOP;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [1:0]  req_tid = '0;
  logic        stall;
  logic        offer_valid;
  logic        ack = 1'b0;
  logic [9:0]  offer_rq;
  t_opcode     offer_op;
  logic [31:0] offer_addr, offer_data;
  logic        rin_valid = 1'b0;
  logic [9:0]  rin_rq = '0;
  t_opcode     rin_op = OP_NOP;
  logic [31:0] rin_data = '0;
  logic        consume;
  logic        rsp_valid;
  t_opcode     rsp_op;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tid;

  int   n_cmp = 0;
  int   n_bad = 0;
  t_iss q_iss[$];
  t_rsp q_rsp[$];
  t_iss m_iss;
  t_rsp m_rsp;

  c2f_gen2 dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CORE),
    .C2F_ReqValidQ500H(req_valid), .C2F_ReqOpcodeQ500H(req_op),
    .C2F_ReqAddressQ500H(req_addr), .C2F_ReqDataQ500H(req_data),
    .C2F_ReqThreadIDQ500H(req_tid), .C2F_ReqStall(stall),
    .C2F_ReqValidQ501H(offer_valid), .C2F_ReqAckQ501H(ack),
    .C2F_ReqRequestorQ501H(offer_rq), .C2F_ReqOpcodeQ501H(offer_op),
    .C2F_ReqAddressQ501H(offer_addr), .C2F_ReqDataQ501H(offer_data),
    .RingRspInValidQ501H(rin_valid), .RingRspInRequestorQ501H(rin_rq),
    .RingRspInOpcodeQ501H(rin_op), .RingRspInDataQ501H(rin_data),
    .C2F_RingConsumeQ501H(consume), .C2F_RspValidQ502H(rsp_valid),
    .C2F_RspOpcodeQ502H(rsp_op), .C2F_RspDataQ502H(rsp_data),
    .C2F_RspThreadIDQ502H(rsp_tid)
  );

  always #5 QClk = ~QClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic req(input t_opcode op, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] tid, input int idx, input bit expect_issue);
    t_iss e;
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_tid = tid;
    e.rq = {CORE, idx[1:0]}; e.op = op; e.addr = a; e.data = d;
    if (expect_issue) q_iss.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ring(input logic [7:0] cid, input int idx, input t_opcode op,
                      input logic [31:0] d, input logic exp_consume, input string name);
    rin_valid = 1'b1; rin_rq = {cid, idx[1:0]}; rin_op = op; rin_data = d;
    #2;
    chk(name, consume, exp_consume);
    tick();
    rin_valid = 1'b0;
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic [1:0] tid);
    t_rsp e;
    e.data = d; e.tid = tid;
    q_rsp.push_back(e);
  endtask

  always @(negedge QClk) begin
    if (RstQnnnL) begin
      if (req_valid && stall) begin
        n_cmp++; n_bad++;
        $display("FAIL req_while_stalled: bench drove ReqValid with stall=1");
      end
      if (offer_valid && ack) begin
        if (q_iss.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got rq %0h op %0h expected none", offer_rq, offer_op);
        end else begin
          m_iss = q_iss.pop_front();
          chk("issue_rq", offer_rq, m_iss.rq);
          chk("issue_op", offer_op, m_iss.op);
          chk("issue_addr", offer_addr, m_iss.addr);
          chk("issue_data", offer_data, m_iss.data);
        end
      end
      if (rsp_valid) begin
        if (q_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got data %0h expected none", rsp_data);
        end else begin
          m_rsp = q_rsp.pop_front();
          chk("rsp_op", rsp_op, OP_RD_RSP);
          chk("rsp_data", rsp_data, m_rsp.data);
          chk("rsp_tid", rsp_tid, m_rsp.tid);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge QClk);
    #3;
    chk("rst_offer_valid", offer_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_consume", consume, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    RstQnnnL = 1'b1;
    tick();

    // single read round trip
    req(OP_RD, 32'h0100_0040, 32'h0, 2'd2, 0, 1'b1);
    ack = 1'b1;
    #2;
    chk("rd_offer_latency", offer_valid, 1'b1);
    tick();
    ack = 1'b0;
    push_rsp(32'hDEAD_BEEF, 2'd2);
    ring(CORE, 0, OP_RD_RSP, 32'hDEAD_BEEF, 1'b1, "rd_consume");
    #2;
    chk("rd_rsp_not_at_m1", rsp_valid, 1'b0);
    tick();
    #2;
    chk("rd_rsp_at_m2", rsp_valid, 1'b1);
    tick();

    // fill with writes, stall, then drain in order
    for (int i = 0; i < 4; i++) begin
      req(OP_WR, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 2'd0, i, 1'b1);
      #2;
      chk("stall_fill", stall, (i == 3));
    end
    ack = 1'b1;
    tick();
    #2;
    chk("stall_release", stall, 1'b0);
    repeat (3) tick();
    ack = 1'b0;
    #2;
    chk("wr_drained", offer_valid, 1'b0);
    tick();

    // two reads returned out of order
    req(OP_RD, 32'h200, 32'h0, 2'd1, 0, 1'b1);
    req(OP_RD, 32'h204, 32'h0, 2'd3, 1, 1'b1);
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    push_rsp(32'h1111_1111, 2'd3);
    push_rsp(32'h2222_2222, 2'd1);
    ring(CORE, 1, OP_RD_RSP, 32'h1111_1111, 1'b1, "rd1_consume");
    ring(CORE, 0, OP_RD_RSP, 32'h2222_2222, 1'b1, "rd0_consume");
    repeat (3) tick();

    // write-broadcast retire
    req(OP_WR_BCAST, 32'h300, 32'hBCBC_0001, 2'd0, 0, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ring(8'h33, 0, OP_WR_BCAST, 32'h0, 1'b0, "bc_foreign_no_consume");
    ring(CORE, 0, OP_RD_RSP, 32'h0, 1'b0, "bc_wrong_op_no_consume");
    ring(CORE, 0, OP_WR_BCAST, 32'h0, 1'b1, "bc_own_consume");
    req(OP_WR, 32'h304, 32'h5555, 2'd0, 0, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // alloc, ack, match and delivery in one cycle
    req(OP_RD, 32'h400, 32'h0, 2'd0, 0, 1'b1);
    req(OP_RD, 32'h404, 32'h0, 2'd1, 1, 1'b1);
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    req(OP_WR, 32'h408, 32'h77, 2'd0, 2, 1'b1);
    push_rsp(32'hE0E0, 2'd0);
    ring(CORE, 0, OP_RD_RSP, 32'hE0E0, 1'b1, "sim_setup_consume");
    push_rsp(32'hE1E1, 2'd1);
    rin_valid = 1'b1; rin_rq = {CORE, 2'd1}; rin_op = OP_RD_RSP; rin_data = 32'hE1E1;
    ack = 1'b1;
    req(OP_WR, 32'h40C, 32'h88, 2'd0, 3, 1'b1);
    ack = 1'b0;
    rin_valid = 1'b0;
    #2;
    chk("sim_delivered", rsp_valid, 1'b1);
    chk("sim_no_stall", stall, 1'b0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (3) tick();

    // reset in the middle of traffic
    req(OP_RD, 32'h500, 32'h0, 2'd0, 0, 1'b1);
    req(OP_RD, 32'h504, 32'h0, 2'd0, 1, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #2;
    chk("pre_reset_offer", offer_valid, 1'b1);
    #1;
    RstQnnnL = 1'b0;
    #1;
    chk("mid_rst_offer_valid", offer_valid, 1'b0);
    chk("mid_rst_offer_addr", offer_addr, 32'h0);
    chk("mid_rst_offer_rq", offer_rq, 10'h0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    RstQnnnL = 1'b1;
    tick();
    ring(CORE, 0, OP_RD_RSP, 32'hBAD0_0BAD, 1'b0, "stale_tag_ignored");
    repeat (4) tick();

    chk("issue_queue_drained", q_iss.size(), 0);
    chk("rsp_queue_drained", q_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
